// File: rtl/w5300_common_init_seq_pkg.sv
// w5300_pkg: shared definitions for the W5300 common-register power-up sequencer.
//   - LUT entry field positions {op[26], addr[25:16], value[15:0]}
//   - bus direction encodings, MR register offset
//   - sequencer state and pass enumerations
//   - max3() helper used to size the shared delay counter
package w5300_pkg;

    localparam int unsigned LUT_W    = 27;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 16;

    localparam int unsigned OP_BIT   = 26;
    localparam int unsigned ADDR_MSB = 25;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned VAL_MSB  = 15;
    localparam int unsigned VAL_LSB  = 0;

    // bus_we encodings
    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    // Mode register offset; it is written but never read back
    localparam logic [ADDR_W-1:0] MR_ADDR = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HW_RST,
        ST_PLL_WAIT,
        ST_FETCH,
        ST_XFER,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic {
        PASS_WR = 1'b0,
        PASS_RD = 1'b1
    } pass_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/w5300_common_init_seq_delay_cnt.sv
// w5300_delay_cnt: loadable down-counter with zero flag.
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : load i_value this cycle (takes priority over counting)
//   i_value   : load value
//   o_zero    : counter is at zero; counting stops there
module w5300_delay_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/w5300_common_init_seq.sv
// w5300_common_init_seq: power-up sequencer for the W5300 common register block.
// Pulses the chip hardware reset, waits for PLL lock, writes every config LUT entry
// over the host-bus layer and (VERIFY != 0) reads each one back and compares.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : start pulse, honoured in IDLE/DONE/ERROR only
//   lut_index    : LUT entry index;  lut_data : {op, addr, value}, combinational
//   bus_req/bus_we/bus_addr/bus_wdata : request to host-bus layer
//   bus_ack/bus_rdata : completion strobe and read data
//   w5300_rst_n  : W5300 hardware reset (active-low)
//   busy, done, error, err_index : status (done/error sticky)
module w5300_common_init_seq
    import w5300_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 200,
    parameter int unsigned PLL_CYCLES  = 1000000,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned VERIFY      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  lut_index,
    input  logic [26:0] lut_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        w5300_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  err_index
);

    // The ack timeout shares this counter, so it is included in the sizing too.
    localparam int unsigned CW = $clog2(max3(RST_CYCLES, PLL_CYCLES, ACK_TIMEOUT) + 1);

    state_e      r_state, w_state;
    pass_e       r_pass,  w_pass;
    logic [5:0]  r_idx,   w_idx;
    logic        r_wrap,  w_wrap;
    logic        r_req,   w_req;
    logic        r_we,    w_we;
    logic [9:0]  r_addr,  w_addr;
    logic [15:0] r_wdata, w_wdata;
    logic [15:0] r_rdata, w_rdata;
    logic        r_rst_n, w_rst_n;
    logic        r_busy,  w_busy;
    logic        r_done,  w_done;
    logic        r_error, w_error;
    logic [5:0]  r_eidx,  w_eidx;

    logic          w_cnt_load;
    logic [CW-1:0] w_cnt_val;
    logic          w_cnt_zero;
    logic [6:0]    w_idx_sum;
    logic          w_entry_end;

    w5300_delay_cnt #(.W(CW)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_val),
        .o_zero  (w_cnt_zero)
    );

    // Carry out of the 6-bit index marks the wrap that ends a pass.
    assign w_idx_sum   = {1'b0, r_idx} + 7'd1;
    assign w_entry_end = lut_data[OP_BIT] | r_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pass  <= PASS_WR;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rst_n <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_eidx  <= '0;
        end else begin
            r_state <= w_state;
            r_pass  <= w_pass;
            r_idx   <= w_idx;
            r_wrap  <= w_wrap;
            r_req   <= w_req;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_rdata <= w_rdata;
            r_rst_n <= w_rst_n;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_error <= w_error;
            r_eidx  <= w_eidx;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_pass     = r_pass;
        w_idx      = r_idx;
        w_wrap     = r_wrap;
        w_req      = r_req;
        w_we       = r_we;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_rdata    = r_rdata;
        w_rst_n    = r_rst_n;
        w_busy     = r_busy;
        w_done     = r_done;
        w_error    = r_error;
        w_eidx     = r_eidx;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;

        case (r_state)
            ST_HW_RST: begin
                if (w_cnt_zero) begin
                    w_state    = ST_PLL_WAIT;
                    w_rst_n    = 1'b1;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = CW'(PLL_CYCLES - 1);
                end
            end
            ST_PLL_WAIT: begin
                if (w_cnt_zero) begin
                    w_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_entry_end) begin
                    if (r_pass == PASS_WR && VERIFY != 0) begin
                        w_pass = PASS_RD;
                        w_idx  = '0;
                        w_wrap = 1'b0;
                    end else begin
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                    end
                end else if (r_pass == PASS_RD && lut_data[ADDR_MSB:ADDR_LSB] == MR_ADDR) begin
                    w_idx  = w_idx_sum[5:0];
                    w_wrap = w_idx_sum[6];
                end else begin
                    w_addr     = lut_data[ADDR_MSB:ADDR_LSB];
                    w_wdata    = lut_data[VAL_MSB:VAL_LSB];
                    w_we       = (r_pass == PASS_WR) ? OP_WR : OP_RD;
                    w_req      = 1'b1;
                    w_state    = ST_XFER;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = CW'(ACK_TIMEOUT - 1);
                end
            end
            ST_XFER: begin
                if (bus_ack) begin
                    w_req = 1'b0;
                    if (r_pass == PASS_WR) begin
                        w_idx   = w_idx_sum[5:0];
                        w_wrap  = w_idx_sum[6];
                        w_state = ST_FETCH;
                    end else begin
                        w_rdata = bus_rdata;
                        w_state = ST_CHECK;
                    end
                end else if (w_cnt_zero) begin
                    w_req   = 1'b0;
                    w_state = ST_ERROR;
                    w_error = 1'b1;
                    w_eidx  = r_idx;
                    w_busy  = 1'b0;
                end
            end
            ST_CHECK: begin
                if (r_rdata != r_wdata) begin
                    w_state = ST_ERROR;
                    w_error = 1'b1;
                    w_eidx  = r_idx;
                    w_busy  = 1'b0;
                end else begin
                    w_idx   = w_idx_sum[5:0];
                    w_wrap  = w_idx_sum[6];
                    w_state = ST_FETCH;
                end
            end
            default: begin  // IDLE, DONE, ERROR
                w_rst_n = 1'b1;
                if (start) begin
                    w_state    = ST_HW_RST;
                    w_done     = 1'b0;
                    w_error    = 1'b0;
                    w_eidx     = '0;
                    w_idx      = '0;
                    w_wrap     = 1'b0;
                    w_pass     = PASS_WR;
                    w_busy     = 1'b1;
                    w_rst_n    = 1'b0;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = CW'(RST_CYCLES - 1);
                end
            end
        endcase
    end

    assign lut_index   = r_idx;
    assign bus_req     = r_req;
    assign bus_we      = r_we;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign w5300_rst_n = r_rst_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_index   = r_eidx;

endmodule

// File: tb/tb_w5300_common_init_seq.sv
// Bench for w5300_common_init_seq: instance A (VERIFY=1, W5300 common-register LUT)
// and instance B (VERIFY=0, random 64-entry LUT without end marker), each driven by
// a behavioural bus responder; results are compared with an expected transaction list.
module tb_w5300_common_init_seq;

    localparam int unsigned RST_C = 4;
    localparam int unsigned PLL_C = 8;
    localparam int unsigned ACK_T = 20;

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A
    logic        a_start = 1'b0;
    logic [5:0]  a_idx;
    logic [26:0] a_lut_data;
    logic        a_req, a_we, a_ack, a_rst_n, a_busy, a_done, a_err;
    logic [9:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic [5:0]  a_eidx;
    // instance B
    logic        b_start = 1'b0;
    logic [5:0]  b_idx;
    logic [26:0] b_lut_data;
    logic        b_req, b_we, b_ack, b_rst_n, b_busy, b_done, b_err;
    logic [9:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [5:0]  b_eidx;

    logic [26:0] lut_a [64];
    logic [26:0] lut_b [64];
    assign a_lut_data = lut_a[a_idx];
    assign b_lut_data = lut_b[b_idx];

    w5300_common_init_seq #(.RST_CYCLES(RST_C), .PLL_CYCLES(PLL_C), .ACK_TIMEOUT(ACK_T),
                            .VERIFY(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .lut_index(a_idx), .lut_data(a_lut_data),
        .bus_req(a_req), .bus_we(a_we), .bus_addr(a_addr), .bus_wdata(a_wdata),
        .bus_ack(a_ack), .bus_rdata(a_rdata), .w5300_rst_n(a_rst_n), .busy(a_busy),
        .done(a_done), .error(a_err), .err_index(a_eidx));

    w5300_common_init_seq #(.RST_CYCLES(RST_C), .PLL_CYCLES(PLL_C), .ACK_TIMEOUT(ACK_T),
                            .VERIFY(0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .lut_index(b_idx), .lut_data(b_lut_data),
        .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr), .bus_wdata(b_wdata),
        .bus_ack(b_ack), .bus_rdata(b_rdata), .w5300_rst_n(b_rst_n), .busy(b_busy),
        .done(b_done), .error(b_err), .err_index(b_eidx));

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus responder A (register file, fault hooks) ----------------
    txn_t        log_a[$];
    txn_t        log_b[$];
    logic [15:0] mem_a [1024];
    int          a_fixed = 0;       // 0: random ack delay 1..4
    logic        a_noack_en = 1'b0;
    logic [9:0]  a_noack_addr = '0;
    logic        a_bad_en = 1'b0;
    logic [9:0]  a_bad_addr = '0;
    int          a_last_len = 0;

    initial begin
        int   wc, dly;
        logic ackd;
        txn_t snap;
        logic [15:0] rd;
        wc = 0; dly = 1; ackd = 1'b0; snap = '0;
        a_ack = 1'b0; a_rdata = '0;
        foreach (mem_a[i]) mem_a[i] = '0;
        forever begin
            @(negedge clk);
            if (ackd) check("req_after_ack", 32'(a_req), 32'(0));
            ackd  = 1'b0;
            a_ack = 1'b0;
            if (a_req) begin
                if (wc == 0) begin
                    dly  = (a_fixed != 0) ? a_fixed : int'($urandom_range(1, 4));
                    snap = '{a_we, a_addr, a_wdata};
                end
                wc++;
                if (wc == dly && !(a_we && a_noack_en && a_addr == a_noack_addr)) begin
                    check("req_stable", 32'(txn_t'{a_we, a_addr, a_wdata}), 32'(snap));
                    if (a_we) begin
                        mem_a[a_addr] = a_wdata;
                        log_a.push_back('{1'b1, a_addr, a_wdata});
                    end else begin
                        rd = (a_bad_en && a_addr == a_bad_addr) ? 16'h0000 : mem_a[a_addr];
                        a_rdata = rd;
                        log_a.push_back('{1'b0, a_addr, rd});
                    end
                    a_ack = 1'b1;
                    ackd  = 1'b1;
                end
            end else begin
                if (wc != 0) a_last_len = wc;
                wc = 0;
            end
        end
    end

    // ---------------- bus responder B (write-only logging) ----------------
    initial begin
        int wc, dly;
        wc = 0; dly = 1;
        b_ack = 1'b0; b_rdata = '0;
        forever begin
            @(negedge clk);
            b_ack = 1'b0;
            if (b_req) begin
                if (wc == 0) dly = int'($urandom_range(1, 4));
                wc++;
                if (wc == dly) begin
                    log_b.push_back('{b_we, b_addr, b_wdata});
                    b_ack = 1'b1;
                end
            end else begin
                wc = 0;
            end
        end
    end

    int   a_rst_falls = 0;
    initial begin
        logic prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !a_rst_n) a_rst_falls++;
            prev = a_rst_n;
        end
    end

    // ---------------- reference model ----------------
    txn_t exp_q[$];

    // Write pass over all entries up to end marker / 64; read pass skips MR (addr 0).
    function automatic void build_exp(input bit use_b, input bit verify);
        logic [26:0] e;
        int n;
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 64; i++) begin
            e = use_b ? lut_b[i] : lut_a[i];
            if (e[26]) break;
            exp_q.push_back('{1'b1, e[25:16], e[15:0]});
            n++;
        end
        if (verify)
            for (int i = 0; i < n; i++) begin
                e = use_b ? lut_b[i] : lut_a[i];
                if (e[25:16] != 10'h000) exp_q.push_back('{1'b0, e[25:16], e[15:0]});
            end
    endfunction

    function automatic int first_idx_of(input logic [9:0] addr);
        for (int i = 0; i < 64; i++) begin
            if (lut_a[i][26]) break;
            if (lut_a[i][25:16] == addr) return i;
        end
        return -1;
    endfunction

    task automatic compare_log(input string tag, input bit use_b);
        int n;
        txn_t t;
        n = use_b ? log_b.size() : log_a.size();
        check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            t = use_b ? log_b[i] : log_a[i];
            check($sformatf("%s_txn%0d", tag, i), 32'(t), 32'(exp_q[i]));
        end
    endtask

    task automatic pulse_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a_end(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (a_done || a_err) begin ok = 1'b1; break; end
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_idx"},   32'(a_idx),   32'(0));
        check({tag, "_req"},   32'(a_req),   32'(0));
        check({tag, "_we"},    32'(a_we),    32'(0));
        check({tag, "_addr"},  32'(a_addr),  32'(0));
        check({tag, "_wdata"}, 32'(a_wdata), 32'(0));
        check({tag, "_rstn"},  32'(a_rst_n), 32'(1));
        check({tag, "_busy"},  32'(a_busy),  32'(0));
        check({tag, "_done"},  32'(a_done),  32'(0));
        check({tag, "_err"},   32'(a_err),   32'(0));
        check({tag, "_eidx"},  32'(a_eidx),  32'(0));
    endtask

    initial begin
        bit ok;
        int lowc;
        bit seen_low;
        int e_idx;

        foreach (lut_a[i]) lut_a[i] = {1'b1, 26'h0};
        lut_a[0]  = {1'b0, 10'h000, 16'hB800};  // MR
        lut_a[1]  = {1'b0, 10'h004, 16'h00FF};  // IMR
        lut_a[2]  = {1'b0, 10'h008, 16'h0008};  // SHAR
        lut_a[3]  = {1'b0, 10'h00A, 16'hDC01};  // SHAR2
        lut_a[4]  = {1'b0, 10'h00C, 16'h0203};  // SHAR4
        lut_a[5]  = {1'b0, 10'h010, 16'hC0A8};  // GAR
        lut_a[6]  = {1'b0, 10'h012, 16'h0001};  // GAR2
        lut_a[7]  = {1'b0, 10'h014, 16'hFFFF};  // SUBR
        lut_a[8]  = {1'b0, 10'h016, 16'hFF00};  // SUBR2
        lut_a[9]  = {1'b0, 10'h018, 16'hC0A8};  // SIPR
        lut_a[10] = {1'b0, 10'h01A, 16'h000A};  // SIPR2
        lut_a[11] = {1'b0, 10'h01C, 16'h07D0};  // RTR
        lut_a[12] = {1'b0, 10'h01E, 16'h0008};  // RCR
        lut_a[13] = {1'b0, 10'h020, 16'h0808};  // TMSR
        lut_a[14] = {1'b0, 10'h030, 16'h00FF};  // MTYPER
        foreach (lut_b[i]) lut_b[i] = {1'b0, 10'($urandom_range(1, 1023)), 16'($urandom())};

        repeat (3) @(negedge clk);
        check_reset_a("rst");
        check("rst_b_busy", 32'(b_busy), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1: full sequence, fixed 2-cycle ack
        a_fixed = 2;
        log_a.delete();
        pulse_a();
        check("t1_busy", 32'(a_busy), 32'(1));
        lowc = 0; seen_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!a_rst_n) begin lowc++; seen_low = 1'b1; end
            else if (seen_low) break;
            @(negedge clk);
        end
        check("t1_rst_low_cycles", 32'(lowc), 32'(RST_C));
        wait_a_end(2000, ok);
        check("t1_timeout", 32'(ok), 32'(1));
        check("t1_done", 32'(a_done), 32'(1));
        check("t1_err", 32'(a_err), 32'(0));
        check("t1_busy_end", 32'(a_busy), 32'(0));
        build_exp(1'b0, 1'b1);
        compare_log("t1", 1'b0);

        // 2: corrupted readback of SHAR2
        a_fixed = 0;
        a_bad_en = 1'b1; a_bad_addr = 10'h00A;
        e_idx = first_idx_of(10'h00A);
        pulse_a();
        check("t2_done_cleared", 32'(a_done), 32'(0));
        wait_a_end(2000, ok);
        check("t2_timeout", 32'(ok), 32'(1));
        check("t2_err", 32'(a_err), 32'(1));
        check("t2_eidx", 32'(a_eidx), 32'(e_idx));
        check("t2_done", 32'(a_done), 32'(0));
        a_bad_en = 1'b0;

        // 3: write to GAR never acknowledged
        a_noack_en = 1'b1; a_noack_addr = 10'h010;
        e_idx = first_idx_of(10'h010);
        pulse_a();
        check("t3_err_cleared", 32'(a_err), 32'(0));
        wait_a_end(2000, ok);
        check("t3_timeout", 32'(ok), 32'(1));
        @(negedge clk);
        check("t3_err", 32'(a_err), 32'(1));
        check("t3_eidx", 32'(a_eidx), 32'(e_idx));
        check("t3_req", 32'(a_req), 32'(0));
        check("t3_req_len", 32'(a_last_len), 32'(ACK_T));
        check("t3_busy", 32'(a_busy), 32'(0));
        a_noack_en = 1'b0;

        // 4: async reset during XFER of index 7, then full rerun
        pulse_a();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (a_req && a_idx == 6'd7) begin ok = 1'b1; break; end
        end
        check("t4_reach_idx7", 32'(ok), 32'(1));
        rst = 1'b1;
        #1;
        check_reset_a("t4_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        log_a.delete();
        pulse_a();
        check("t4_rerun_rstn", 32'(a_rst_n), 32'(0));
        wait_a_end(2000, ok);
        check("t4_timeout", 32'(ok), 32'(1));
        check("t4_done", 32'(a_done), 32'(1));
        build_exp(1'b0, 1'b1);
        compare_log("t4", 1'b0);

        // 5: start ignored while busy, honoured after done
        log_a.delete();
        a_rst_falls = 0;
        pulse_a();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_rst_n) begin ok = 1'b1; break; end
        end
        check("t5_reach_pll", 32'(ok), 32'(1));
        pulse_a();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("t5_reach_xfer", 32'(ok), 32'(1));
        pulse_a();
        wait_a_end(2000, ok);
        check("t5_timeout", 32'(ok), 32'(1));
        check("t5_done", 32'(a_done), 32'(1));
        check("t5_rst_falls", 32'(a_rst_falls), 32'(1));
        compare_log("t5", 1'b0);
        pulse_a();
        check("t5_restart_busy", 32'(a_busy), 32'(1));
        check("t5_restart_rstn", 32'(a_rst_n), 32'(0));
        check("t5_restart_done", 32'(a_done), 32'(0));
        wait_a_end(2000, ok);
        check("t5_done2", 32'(a_done), 32'(1));

        // 6: VERIFY=0, 64 entries, no end marker
        log_b.delete();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (b_done || b_err) begin ok = 1'b1; break; end
        end
        check("t6_timeout", 32'(ok), 32'(1));
        check("t6_done", 32'(b_done), 32'(1));
        check("t6_err", 32'(b_err), 32'(0));
        check("t6_idx_wrapped", 32'(b_idx), 32'(0));
        build_exp(1'b1, 1'b0);
        compare_log("t6", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
